// File: rtl/ob_port_sequencer_b1.sv
// rtl/ob_port_sequencer_b1.sv - FILL/DRAIN frame sequencer for the eight Block1 output-buffer SRAMs
module ob_port_sequencer_b1 #(
    parameter int AW     = 8,
    parameter int DEPTH  = 226,
    parameter int RD_LAT = 1,
    parameter int NB     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NB-1:0]     wr_req,
    input  logic [NB*AW-1:0]  wr_addr,
    input  logic              wr_last,
    input  logic              rd_req,
    input  logic [AW-1:0]     rd_addr,
    input  logic              rd_last,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [NB-1:0]     ram_en,
    output logic [NB-1:0]     ram_we,
    output logic [NB*AW-1:0]  ram_addr,
    output logic              fill_done,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic [1:0]        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    state_t state;
    state_t state_nxt;

    logic [NB-1:0]     wr_bad;
    logic              rd_bad;
    logic              wr_refused;
    logic              addr_err;
    logic              fill_done_q;
    logic [7:0]        frame_cnt_q;
    logic [1:0]        err_q;
    logic [RD_LAT-1:0] rd_pipe;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            wr_bad[i] = {1'b0, wr_addr[i*AW +: AW]} >= LIMIT;
        end
    end

    assign rd_bad = {1'b0, rd_addr} >= LIMIT;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|wr_req) state_nxt = FILL;
            FILL:    if ((|wr_req) && wr_last) state_nxt = DRAIN;
            DRAIN:   if (rd_req && rd_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range banks keep their address on the bus but are never enabled.
    always_comb begin
        ram_en     = '0;
        ram_we     = '0;
        ram_addr   = '0;
        rd_gnt     = 1'b0;
        frame_done = 1'b0;
        wr_refused = 1'b0;
        addr_err   = 1'b0;
        if (!rst_n) begin
            case (state)
                IDLE, FILL: begin
                    ram_en   = wr_req & ~wr_bad;
                    ram_we   = wr_req & ~wr_bad;
                    ram_addr = wr_addr;
                    addr_err = |(wr_req & wr_bad);
                end
                DRAIN: begin
                    rd_gnt     = rd_req;
                    ram_en     = {NB{rd_req & ~rd_bad}};
                    ram_addr   = {NB{rd_addr}};
                    addr_err   = rd_req & rd_bad;
                    wr_refused = |wr_req;
                end
                DONE: begin
                    frame_done = 1'b1;
                    wr_refused = |wr_req;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fill_done_q <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= '0;
            rd_pipe     <= '0;
        end else begin
            fill_done_q <= (state == FILL) && (state_nxt == DRAIN);
            if (state == DONE) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            err_q      <= err_q | {addr_err, wr_refused};
            rd_pipe[0] <= rd_gnt;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_pipe[k] <= rd_pipe[k-1];
            end
        end
    end

    // Reset masks registered outputs at once so an aborted frame leaks nothing.
    assign fill_done = fill_done_q & ~rst_n;
    assign frame_cnt = rst_n ? 8'd0 : frame_cnt_q;
    assign err       = rst_n ? 2'd0 : err_q;
    assign rd_valid  = rd_pipe[RD_LAT-1] & ~rst_n;

endmodule

// File: tb/tb_ob_port_sequencer_b1.sv
// tb/tb_ob_port_sequencer_b1.sv - vector table and scoreboard bench for ob_port_sequencer_b1
module tb_ob_port_sequencer_b1;
    localparam int AW = 8;
    localparam int NB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [NB-1:0]    wr_req;
    logic [NB*AW-1:0] wr_addr;
    logic             wr_last, rd_req, rd_last;
    logic [AW-1:0]    rd_addr;

    logic             rd_gnt, rd_valid, fill_done, frame_done;
    logic [NB-1:0]    ram_en, ram_we;
    logic [NB*AW-1:0] ram_addr;
    logic [7:0]       frame_cnt;
    logic [1:0]       err;

    logic             rd_gnt_3, rd_valid_3, fill_done_3, frame_done_3;
    logic [NB-1:0]    ram_en_3, ram_we_3;
    logic [NB*AW-1:0] ram_addr_3;
    logic [7:0]       frame_cnt_3;
    logic [1:0]       err_3;

    ob_port_sequencer_b1 #(.AW(8), .DEPTH(226), .RD_LAT(1), .NB(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_last(wr_last),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .fill_done(fill_done), .frame_done(frame_done), .frame_cnt(frame_cnt), .err(err)
    );

    ob_port_sequencer_b1 #(.AW(8), .DEPTH(226), .RD_LAT(3), .NB(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_last(wr_last),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_gnt(rd_gnt_3),
        .rd_valid(rd_valid_3), .ram_en(ram_en_3), .ram_we(ram_we_3), .ram_addr(ram_addr_3),
        .fill_done(fill_done_3), .frame_done(frame_done_3), .frame_cnt(frame_cnt_3), .err(err_3)
    );

    typedef struct {
        logic        rst;
        logic [7:0]  wq;
        logic [63:0] wa;
        logic        wl;
        logic        rq;
        logic [7:0]  ra;
        logic        rl;
        logic [7:0]  en;
        logic [7:0]  we;
        logic [63:0] ea;
        logic        gnt;
        logic        fd;
        logic        fr;
        logic [1:0]  e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int q1[$];
    int q3[$];
    int hits [NB][256];
    int wr_total = 0;
    logic [1:0] exp_err = 2'b00;
    logic [7:0] exp_cnt = 8'd0;
    vec_t vt [8];

    // SRAM side: count every enabled write per bank and word.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (ram_en[b] && ram_we[b]) begin
                hits[b][ram_addr[b*AW +: AW]]++;
                wr_total++;
            end
        end
    end

    function automatic logic [63:0] rep(input logic [7:0] a);
        return {8{a}};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [7:0] wq, input logic [63:0] wa,
                                input logic wl, input logic rq, input logic [7:0] ra,
                                input logic rl, input logic [7:0] en, input logic [7:0] we,
                                input logic [63:0] ea, input logic gnt, input logic fd,
                                input logic fr, input logic [1:0] e_err, input logic [7:0] e_cnt);
        vec_t v;
        v.rst = rst; v.wq = wq; v.wa = wa; v.wl = wl; v.rq = rq; v.ra = ra; v.rl = rl;
        v.en = en; v.we = we; v.ea = ea; v.gnt = gnt; v.fd = fd; v.fr = fr;
        v.e_err = e_err; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %h want %h", nm, idx, got, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        logic ev1, ev3;
        rst_n = v.rst; wr_req = v.wq; wr_addr = v.wa; wr_last = v.wl;
        rd_req = v.rq; rd_addr = v.ra; rd_last = v.rl;
        #1;
        if (v.rst) begin
            q1.delete();
            q3.delete();
        end
        chk("ram_en", idx, 64'(ram_en), 64'(v.en));
        chk("ram_we", idx, 64'(ram_we), 64'(v.we));
        chk("rd_gnt", idx, 64'(rd_gnt), 64'(v.gnt));
        chk("fill_done", idx, 64'(fill_done), 64'(v.fd));
        chk("frame_done", idx, 64'(frame_done), 64'(v.fr));
        chk("err", idx, 64'(err), 64'(v.e_err));
        chk("frame_cnt", idx, 64'(frame_cnt), 64'(v.e_cnt));
        for (int b = 0; b < NB; b++) begin
            if (v.en[b]) chk("ram_addr", idx, 64'(ram_addr[b*AW +: AW]), 64'(v.ea[b*AW +: AW]));
        end
        ev1 = (q1.size() > 0) && (q1[0] == cyc);
        ev3 = (q3.size() > 0) && (q3[0] == cyc);
        if (ev1) void'(q1.pop_front());
        if (ev3) void'(q3.pop_front());
        chk("rd_valid_lat1", idx, 64'(rd_valid), 64'(ev1));
        chk("rd_valid_lat3", idx, 64'(rd_valid_3), 64'(ev3));
        if (v.gnt && !v.rst) begin
            q1.push_back(cyc + 1);
            q3.push_back(cyc + 3);
        end
        if (v.rst) begin
            exp_err = 2'b00;
            exp_cnt = 8'd0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_row(input int idx);
        step(mk(1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00, 64'd0,
                1'b0, 1'b0, 1'b0, exp_err, exp_cnt), idx);
    endtask

    task automatic rst_row(input int idx, input logic [7:0] wq);
        step(mk(1'b1, wq, rep(8'd1), 1'b0, 1'b1, 8'd2, 1'b0, 8'h00, 8'h00, 64'd0,
                1'b0, 1'b0, 1'b0, 2'b00, 8'd0), idx);
    endtask

    // Minimal frame: IDLE write, FILL write with last (read stalled), one read, DONE.
    task automatic sframe(input int idx);
        step(mk(1'b0, 8'hFF, rep(8'd7), 1'b0, 1'b0, 8'd0, 1'b0, 8'hFF, 8'hFF, rep(8'd7),
                1'b0, 1'b0, 1'b0, exp_err, exp_cnt), idx);
        step(mk(1'b0, 8'hFF, rep(8'd8), 1'b1, 1'b1, 8'd9, 1'b0, 8'hFF, 8'hFF, rep(8'd8),
                1'b0, 1'b0, 1'b0, exp_err, exp_cnt), idx);
        step(mk(1'b0, 8'h00, 64'd0, 1'b0, 1'b1, 8'd9, 1'b1, 8'hFF, 8'h00, rep(8'd9),
                1'b1, 1'b1, 1'b0, exp_err, exp_cnt), idx);
        step(mk(1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00, 64'd0,
                1'b0, 1'b0, 1'b1, exp_err, exp_cnt), idx);
        exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        logic [63:0] wa3, wa5;
        int w0, h5;
        logic first;
        wa3 = 64'h46_3C_32_28_1E_14_0A_00;
        wa5 = {48'd0, 8'd12, 8'd240};
        for (int i = 0; i < 3; i++)
            vt[i] = mk(1'b1, 8'hFF, rep(8'd3), 1'b0, 1'b1, 8'd2, 1'b0, 8'h00, 8'h00, 64'd0,
                       1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        vt[3] = mk(1'b0, 8'hA5, wa3, 1'b0, 1'b1, 8'd4, 1'b0, 8'hA5, 8'hA5, wa3,
                   1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        vt[4] = mk(1'b0, 8'h00, wa3, 1'b0, 1'b1, 8'd4, 1'b0, 8'h00, 8'h00, 64'd0,
                   1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        vt[5] = mk(1'b0, 8'h03, wa5, 1'b0, 1'b0, 8'd0, 1'b0, 8'h02, 8'h02, wa5,
                   1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        vt[6] = mk(1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00, 64'd0,
                   1'b0, 1'b0, 1'b0, 2'b10, 8'd0);
        vt[7] = mk(1'b1, 8'hFF, 64'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00, 64'd0,
                   1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        for (int i = 0; i < 8; i++) step(vt[i], i);

        // Full frame fill with reads requested throughout (must stall).
        w0 = wr_total;
        for (int a = 0; a < 226; a++)
            step(mk(1'b0, 8'hFF, rep(a[7:0]), a == 225, 1'b1, a[7:0], 1'b0, 8'hFF, 8'hFF,
                    rep(a[7:0]), 1'b0, 1'b0, 1'b0, exp_err, exp_cnt), 100 + a);
        chk("fill_writes", 0, 64'(wr_total - w0), 64'd1808);

        h5 = hits[0][5];
        first = 1'b1;
        for (int a = 0; a < 226; a++) begin
            if (a == 10) begin
                step(mk(1'b0, 8'h01, rep(8'd5), 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 8'h00, 64'd0,
                        1'b0, 1'b0, 1'b0, exp_err, exp_cnt), 400);
                exp_err = exp_err | 2'b01;
            end
            if (a == 20) begin
                step(mk(1'b0, 8'h00, 64'd0, 1'b0, 1'b1, 8'd230, 1'b0, 8'h00, 8'h00, 64'd0,
                        1'b1, 1'b0, 1'b0, exp_err, exp_cnt), 401);
                exp_err = exp_err | 2'b10;
            end
            step(mk(1'b0, 8'h00, 64'd0, 1'b0, 1'b1, a[7:0], a == 225, 8'hFF, 8'h00,
                    rep(a[7:0]), 1'b1, first, 1'b0, exp_err, exp_cnt), 500 + a);
            first = 1'b0;
        end
        chk("word5_untouched", 0, 64'(hits[0][5]), 64'(h5));
        step(mk(1'b0, 8'h00, 64'd0, 1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 8'h00, 64'd0,
                1'b0, 1'b0, 1'b1, exp_err, exp_cnt), 800);
        exp_cnt = exp_cnt + 8'd1;
        for (int i = 0; i < 3; i++) idle_row(810 + i);

        // Reset with a read in flight on both latencies.
        step(mk(1'b0, 8'hFF, rep(8'd7), 1'b0, 1'b0, 8'd0, 1'b0, 8'hFF, 8'hFF, rep(8'd7),
                1'b0, 1'b0, 1'b0, exp_err, exp_cnt), 900);
        step(mk(1'b0, 8'hFF, rep(8'd8), 1'b1, 1'b0, 8'd0, 1'b0, 8'hFF, 8'hFF, rep(8'd8),
                1'b0, 1'b0, 1'b0, exp_err, exp_cnt), 901);
        step(mk(1'b0, 8'h00, 64'd0, 1'b0, 1'b1, 8'd3, 1'b0, 8'hFF, 8'h00, rep(8'd3),
                1'b1, 1'b1, 1'b0, exp_err, exp_cnt), 902);
        rst_row(903, 8'h00);
        for (int i = 0; i < 4; i++) idle_row(904 + i);

        // Reset at write 100 of a fill.
        for (int a = 0; a < 100; a++)
            step(mk(1'b0, 8'hFF, rep(a[7:0]), 1'b0, 1'b0, 8'd0, 1'b0, 8'hFF, 8'hFF,
                    rep(a[7:0]), 1'b0, 1'b0, 1'b0, exp_err, exp_cnt), 1000 + a);
        rst_row(1100, 8'hFF);
        step(mk(1'b0, 8'h00, 64'd0, 1'b0, 1'b1, 8'd4, 1'b0, 8'h00, 8'h00, 64'd0,
                1'b0, 1'b0, 1'b0, 2'b00, 8'd0), 1101);

        for (int f = 0; f < 256; f++) sframe(2000 + f);
        idle_row(2300);
        chk("frame_cnt_wrap", 0, 64'(frame_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
